// File: rtl/activation_cache_arbiter.sv
// activation_cache_arbiter
// Shares one 5-way activation cache between NREQ requesters. Requester 0 is the
// layer-output writer and the rest are PE activation readers. The arbiter grants
// round-robin, drives the cache pins for the 2-cycle access, enforces the cache's
// sequencing rules and returns read data or write status to the granted requester.
//
// Optional feature: define ACT_CACHE_ARB_PRIORITY_EN to make requester 0 win whenever
// it is eligible. The rr pointer then rotates over requesters 1..NREQ-1 only.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   req_valid/rw/addr/wdata  per-requester request (rw: 1 = read, 0 = write)
//   req_ready             one-hot grant pulse (combinational accept)
//   rsp_valid/data/full   one-hot completion pulse, read data, write rejected (set full)
//   cache_*               cache request/read_write/address/activation pins
//   busy                  access in flight (A1/A2/GAP)
//   error                 sticky fault flag, cleared only by reset
module activation_cache_arbiter #(
  parameter int unsigned NREQ          = 4,
  parameter int unsigned ADDRESS_WIDTH = 21,
  parameter int unsigned WORD_SIZE     = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ-1:0]               req_rw,
  input  logic [NREQ*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NREQ*WORD_SIZE-1:0]     req_wdata,
  output logic [NREQ-1:0]               req_ready,
  output logic [NREQ-1:0]               rsp_valid,
  output logic [WORD_SIZE-1:0]          rsp_data,
  output logic                          rsp_full,
  output logic                          cache_request,
  output logic                          cache_read_write,
  output logic [ADDRESS_WIDTH-1:0]      cache_address,
  output logic [WORD_SIZE-1:0]          cache_activation_in,
  input  logic [WORD_SIZE-1:0]          cache_activation_out,
  input  logic                          cache_valid,
  input  logic                          cache_error,
  output logic                          busy,
  output logic                          error
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_A1    = 3'd1,
    S_A2    = 3'd2,
    S_GAP   = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t                   state;
  logic                     primed;
  logic [IW-1:0]            rr_ptr;
  logic [IW-1:0]            lat_id;
  logic                     lat_rw;
  logic [ADDRESS_WIDTH-1:0] lat_addr;
  logic [WORD_SIZE-1:0]     lat_wdata;

  // Unpacked views of the packed request buses
  logic [ADDRESS_WIDTH-1:0] addr_arr  [NREQ];
  logic [WORD_SIZE-1:0]     wdata_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign wdata_arr[g] = req_wdata[g*WORD_SIZE +: WORD_SIZE];
  end

  // A write finishing cleanly this cycle primes reads, so a read may win the same A2
  logic            write_ok;
  logic            primed_eff;
  logic [NREQ-1:0] elig;

  assign write_ok   = (state == S_A2) && !lat_rw && cache_valid;
  assign primed_eff = primed || write_ok;
  assign elig       = req_valid & (~req_rw | {NREQ{primed_eff}});

  // Arbitration: first eligible requester from rr_ptr upward
  logic          found;
  logic [IW-1:0] win;

  always_comb begin
    int unsigned idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
`ifdef ACT_CACHE_ARB_PRIORITY_EN
    if (elig[0]) begin
      found = 1'b1;
    end
`endif
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(rr_ptr) + k) % NREQ;
`ifdef ACT_CACHE_ARB_PRIORITY_EN
      if (!found && (idx != 0) && elig[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
`else
      if (!found && elig[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
`endif
    end
  end

  // Pointer value after granting win
  logic [IW-1:0] ptr_nxt;

  always_comb begin
    ptr_nxt = rr_ptr;
`ifdef ACT_CACHE_ARB_PRIORITY_EN
    if (win != '0) begin
      if (32'(win) + 1 >= NREQ) ptr_nxt = IW'(1);
      else                      ptr_nxt = win + IW'(1);
    end
`else
    if (32'(win) + 1 >= NREQ) ptr_nxt = '0;
    else                      ptr_nxt = win + IW'(1);
`endif
  end

  // Grant qualification: read->write needs a bubble; a cache error suppresses grants
  logic win_rw;
  logic turn_block;
  logic grant;

  assign win_rw     = req_rw[win];
  assign turn_block = (state == S_A2) && lat_rw && !win_rw;
  assign grant      = found && !turn_block && !cache_error &&
                      ((state == S_IDLE) || (state == S_A2) || (state == S_GAP));

  assign req_ready = grant ? (NREQ'(1) << win) : '0;

  // Cache pins: a write into a full set is withdrawn during A2 so the cache idles
  assign cache_request       = (state == S_A1) ||
                               ((state == S_A2) && !(!lat_rw && !cache_valid));
  assign cache_read_write    = ((state == S_A1) || (state == S_A2)) ? lat_rw : 1'b1;
  assign cache_address       = lat_addr;
  assign cache_activation_in = lat_wdata;
  assign busy                = (state == S_A1) || (state == S_A2) || (state == S_GAP);

  // Controller state, request latch and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      primed    <= 1'b0;
      rr_ptr    <= '0;
      lat_id    <= '0;
      lat_rw    <= 1'b1;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_full  <= 1'b0;
      error     <= 1'b0;
    end else begin
      rsp_valid <= '0;
      rsp_full  <= 1'b0;
      if (grant) begin
        lat_id    <= win;
        lat_rw    <= win_rw;
        lat_addr  <= addr_arr[win];
        lat_wdata <= wdata_arr[win];
        rr_ptr    <= ptr_nxt;
      end
      if (cache_error) begin
        state <= S_FAULT;
        error <= 1'b1;
      end else begin
        case (state)
          S_IDLE: if (grant) state <= S_A1;
          S_A1:   state <= S_A2;
          S_A2: begin
            rsp_valid <= NREQ'(1) << lat_id;
            rsp_data  <= lat_rw ? cache_activation_out : '0;
            rsp_full  <= !lat_rw && !cache_valid;
            if (write_ok) primed <= 1'b1;
            if (grant)                   state <= S_A1;
            else if (found && turn_block) state <= S_GAP;
            else                         state <= S_IDLE;
          end
          S_GAP:   state <= grant ? S_A1 : S_IDLE;
          S_FAULT: state <= S_FAULT;
          default: state <= S_FAULT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_activation_cache_arbiter.sv
// Directed bench for activation_cache_arbiter (default build, pure round-robin).
module tb_activation_cache_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned AW   = 21;
  localparam int unsigned WS   = 16;

  logic               clk;
  logic               reset;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_rw;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*WS-1:0] req_wdata;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [WS-1:0]      rsp_data;
  logic               rsp_full;
  logic               cache_request;
  logic               cache_read_write;
  logic [AW-1:0]      cache_address;
  logic [WS-1:0]      cache_activation_in;
  logic [WS-1:0]      cache_activation_out;
  logic               cache_valid;
  logic               cache_error;
  logic               busy;
  logic               error;

  int n_chk;
  int n_fail;

  activation_cache_arbiter #(.NREQ(NREQ), .ADDRESS_WIDTH(AW), .WORD_SIZE(WS)) dut (
    .clk                  (clk),
    .reset                (reset),
    .req_valid            (req_valid),
    .req_rw               (req_rw),
    .req_addr             (req_addr),
    .req_wdata            (req_wdata),
    .req_ready            (req_ready),
    .rsp_valid            (rsp_valid),
    .rsp_data             (rsp_data),
    .rsp_full             (rsp_full),
    .cache_request        (cache_request),
    .cache_read_write     (cache_read_write),
    .cache_address        (cache_address),
    .cache_activation_in  (cache_activation_in),
    .cache_activation_out (cache_activation_out),
    .cache_valid          (cache_valid),
    .cache_error          (cache_error),
    .busy                 (busy),
    .error                (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs are driven at posedge+1, outputs sampled at posedge+2
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a,
                         input logic [WS-1:0] d);
    req_rw[i]           = rw;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*WS +: WS] = d;
  endtask

  logic [3:0]  t3_ready [10] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                                 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
  logic        t3_creq  [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                                 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0]  t3_rsp   [10] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000,
                                 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
  logic [15:0] t3_data  [10] = '{16'h0, 16'h0, 16'h0, 16'h0000, 16'h0,
                                 16'hA004, 16'h0, 16'hA006, 16'h0, 16'hA008};

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset = 1'b1;
    req_valid = '0;
    req_rw = '0;
    req_addr = '0;
    req_wdata = '0;
    cache_activation_out = '0;
    cache_valid = 1'b1;
    cache_error = 1'b0;

    // Reset state
    cyc();
    cyc();
    reset = 1'b0;
    settle();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_creq", 32'(cache_request), 32'h0);
    chk("rst_rw", 32'(cache_read_write), 32'h1);
    chk("rst_addr", 32'(cache_address), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_error", 32'(error), 32'h0);

    // Read before priming is never granted
    set_req(1, 1'b1, 21'h00040, 16'h0);
    req_valid = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      cyc();
      settle();
      chk("unprimed_ready", 32'(req_ready), 32'h0);
      chk("unprimed_creq", 32'(cache_request), 32'h0);
      chk("unprimed_rw", 32'(cache_read_write), 32'h1);
      chk("unprimed_error", 32'(error), 32'h0);
    end

    // First write from req0, then req2 read granted in the write's A2
    cyc();
    req_valid = 4'b0001;
    set_req(0, 1'b0, 21'h00012, 16'hBEEF);
    settle();
    chk("w1_ready_G", 32'(req_ready), 32'h1);
    chk("w1_creq_G", 32'(cache_request), 32'h0);
    cyc();
    req_valid = 4'b0100;
    set_req(2, 1'b1, 21'h00012, 16'h0);
    cache_activation_out = 16'hBEEF;
    settle();
    chk("w1_creq_A1", 32'(cache_request), 32'h1);
    chk("w1_rw_A1", 32'(cache_read_write), 32'h0);
    chk("w1_addr_A1", 32'(cache_address), 32'h12);
    chk("w1_data_A1", 32'(cache_activation_in), 32'hBEEF);
    chk("w1_ready_A1", 32'(req_ready), 32'h0);
    chk("w1_busy_A1", 32'(busy), 32'h1);
    cyc();
    settle();
    chk("w1_creq_A2", 32'(cache_request), 32'h1);
    chk("w1_rw_A2", 32'(cache_read_write), 32'h0);
    chk("r2_ready_in_A2", 32'(req_ready), 32'h4);
    cyc();
    req_valid = 4'b0000;
    settle();
    chk("w1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("w1_rsp_full", 32'(rsp_full), 32'h0);
    chk("w1_rsp_data", 32'(rsp_data), 32'h0);
    chk("r2_creq_A1", 32'(cache_request), 32'h1);
    chk("r2_rw_A1", 32'(cache_read_write), 32'h1);
    cyc();
    settle();
    chk("r2_rsp_quiet", 32'(rsp_valid), 32'h0);
    cyc();
    settle();
    chk("r2_rsp_valid", 32'(rsp_valid), 32'h4);
    chk("r2_rsp_data", 32'(rsp_data), 32'hBEEF);
    chk("r2_idle_creq", 32'(cache_request), 32'h0);
    chk("r2_idle_busy", 32'(busy), 32'h0);

    // Write from req0, then reads 1,2,3 back-to-back on a 2-cycle cadence
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (k == 0) begin
        set_req(0, 1'b0, 21'h00034, 16'hCAFE);
        req_valid = 4'b0001;
      end else if (k == 1) begin
        for (int i = 1; i < 4; i++) set_req(i, 1'b1, AW'(32'h100 + i), 16'h0);
        req_valid = 4'b1110;
      end else begin
        req_valid = req_valid & ~t3_ready[k-1];
      end
      cache_activation_out = 16'hA000 + 16'(k);
      settle();
      chk($sformatf("rr_ready_k%0d", k), 32'(req_ready), 32'(t3_ready[k]));
      chk($sformatf("rr_creq_k%0d", k), 32'(cache_request), 32'(t3_creq[k]));
      chk($sformatf("rr_rsp_k%0d", k), 32'(rsp_valid), 32'(t3_rsp[k]));
      if (t3_rsp[k] != 4'b0000)
        chk($sformatf("rr_data_k%0d", k), 32'(rsp_data), 32'(t3_data[k]));
    end

    // Read from req1 followed by write from req0: one GAP cycle
    cyc();
    set_req(1, 1'b1, 21'h00050, 16'h0);
    req_valid = 4'b0010;
    cache_activation_out = 16'h5A5A;
    settle();
    chk("ta_r_ready", 32'(req_ready), 32'h2);
    cyc();
    set_req(0, 1'b0, 21'h00077, 16'h1234);
    req_valid = 4'b0001;
    settle();
    chk("ta_r_creq_A1", 32'(cache_request), 32'h1);
    chk("ta_r_rw_A1", 32'(cache_read_write), 32'h1);
    cyc();
    settle();
    chk("ta_no_grant_A2", 32'(req_ready), 32'h0);
    chk("ta_r_creq_A2", 32'(cache_request), 32'h1);
    cyc();
    settle();
    chk("ta_gap_creq", 32'(cache_request), 32'h0);
    chk("ta_gap_rw", 32'(cache_read_write), 32'h1);
    chk("ta_gap_busy", 32'(busy), 32'h1);
    chk("ta_gap_ready", 32'(req_ready), 32'h1);
    chk("ta_r_rsp", 32'(rsp_valid), 32'h2);
    chk("ta_r_data", 32'(rsp_data), 32'h5A5A);
    cyc();
    req_valid = 4'b0000;
    settle();
    chk("ta_w_creq_A1", 32'(cache_request), 32'h1);
    chk("ta_w_rw_A1", 32'(cache_read_write), 32'h0);
    chk("ta_w_addr_A1", 32'(cache_address), 32'h77);
    cyc();
    settle();
    cyc();
    settle();
    chk("ta_w_rsp", 32'(rsp_valid), 32'h1);
    chk("ta_w_full", 32'(rsp_full), 32'h0);

    // Write into a full set: request withdrawn in A2, rsp_full reported
    cyc();
    set_req(0, 1'b0, 21'h00099, 16'h4321);
    req_valid = 4'b0001;
    settle();
    chk("full_ready", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 4'b0000;
    settle();
    chk("full_creq_A1", 32'(cache_request), 32'h1);
    cyc();
    cache_valid = 1'b0;
    settle();
    chk("full_creq_A2", 32'(cache_request), 32'h0);
    cyc();
    cache_valid = 1'b1;
    settle();
    chk("full_rsp", 32'(rsp_valid), 32'h1);
    chk("full_flag", 32'(rsp_full), 32'h1);

    // Cache error beats a same-cycle grant; FAULT is sticky
    cyc();
    set_req(1, 1'b1, 21'h00012, 16'h0);
    req_valid = 4'b0010;
    cache_error = 1'b1;
    settle();
    chk("err_no_ready", 32'(req_ready), 32'h0);
    cyc();
    cache_error = 1'b0;
    settle();
    chk("fault_error", 32'(error), 32'h1);
    chk("fault_busy", 32'(busy), 32'h0);
    chk("fault_creq", 32'(cache_request), 32'h0);
    chk("fault_rw", 32'(cache_read_write), 32'h1);
    for (int c = 0; c < 4; c++) begin
      cyc();
      settle();
      chk("fault_ready", 32'(req_ready), 32'h0);
      chk("fault_error_hold", 32'(error), 32'h1);
    end

    // Reset clears the fault and the primed state
    cyc();
    reset = 1'b1;
    req_valid = 4'b0000;
    cyc();
    reset = 1'b0;
    settle();
    chk("rst2_error", 32'(error), 32'h0);
    cyc();
    req_valid = 4'b0010;
    settle();
    chk("rst2_unprimed", 32'(req_ready), 32'h0);

    // Reset during A1 aborts the access with no response
    cyc();
    set_req(0, 1'b0, 21'h000AA, 16'h0F0F);
    req_valid = 4'b0001;
    settle();
    chk("abort_ready", 32'(req_ready), 32'h1);
    cyc();
    req_valid = 4'b0000;
    reset = 1'b1;
    settle();
    chk("abort_creq_A1", 32'(cache_request), 32'h1);
    cyc();
    reset = 1'b0;
    settle();
    chk("abort_creq", 32'(cache_request), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    cyc();
    settle();
    chk("abort_no_rsp", 32'(rsp_valid), 32'h0);
    cyc();
    settle();
    chk("abort_no_rsp2", 32'(rsp_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
